// File: rtl/ch_scan_scheduler.sv
// Single-pass channel scan scheduler: snapshots requests and grants them one at a time, LSB first, with a start/done handshake.
// Optional watchdog abort of a stalled channel is enabled by defining SCHED_WATCHDOG_EN.
module ch_scan_scheduler #(
  parameter int N_CH    = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic [N_CH-1:0] req_i,
  input  logic            done_i,
  output logic [N_CH-1:0] grant_o,
  output logic            start_o,
  output logic            busy_o,
  output logic            zero_o,
  output logic            cycle_done_o,
  output logic [N_CH-1:0] served_o,
  output logic            timeout_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_SNAP, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  localparam logic [N_CH-1:0] LP_ONE = N_CH'(1);

  if (2**CNT_W <= TIMEOUT) begin : g_cfgCheck
    $error("CNT_W is too narrow to hold TIMEOUT");
  end

  state_t          r_state;
  logic [N_CH-1:0] r_pend;
  logic [N_CH-1:0] r_acc;
  logic [N_CH-1:0] r_grant;
  logic [N_CH-1:0] r_served;
  logic            r_start;
  logic            r_busy;
  logic            r_zero;
  logic            r_cycleDone;

  logic [N_CH-1:0] w_pendCleared;
  logic [N_CH-1:0] w_reqLowest;
  logic [N_CH-1:0] w_pendLowest;
  logic            w_abort;
  logic            w_release;

  // Two's-complement trick isolates the lowest set bit for LSB-first priority.
  assign w_pendCleared = r_pend & ~r_grant;
  assign w_reqLowest   = req_i & (~req_i + LP_ONE);
  assign w_pendLowest  = w_pendCleared & (~w_pendCleared + LP_ONE);
  assign w_release     = done_i | w_abort;

`ifdef SCHED_WATCHDOG_EN
  logic [CNT_W-1:0] r_wdCnt;
  logic [CNT_W-1:0] w_wdNext;
  logic             r_timeout;

  assign w_wdNext = (r_wdCnt == CNT_W'(TIMEOUT)) ? r_wdCnt : r_wdCnt + CNT_W'(1);
  assign w_abort  = (r_state == ST_WAIT) && !done_i && (w_wdNext == CNT_W'(TIMEOUT));

  // Counts WAIT clocks of the current grant; a completion on the limit clock still wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdCnt   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_abort && !flush_i;
      if (r_state == ST_ISSUE) begin
        r_wdCnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wdCnt <= w_wdNext;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_abort   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Main sequencer; every output is registered alongside the state transition that implies it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_acc       <= '0;
      r_grant     <= '0;
      r_served    <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_zero      <= 1'b0;
      r_cycleDone <= 1'b0;
    end else begin
      r_start     <= 1'b0;
      r_zero      <= 1'b0;
      r_cycleDone <= 1'b0;
      if (flush_i && r_state != ST_IDLE) begin
        r_state <= ST_IDLE;
        r_pend  <= '0;
        r_grant <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (en_i) begin
              r_state <= ST_SNAP;
              r_busy  <= 1'b1;
            end
          end
          ST_SNAP: begin
            r_pend <= req_i;
            r_acc  <= '0;
            if (req_i == '0) begin
              r_state <= ST_IDLE;
              r_zero  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_ISSUE;
              r_grant <= w_reqLowest;
              r_start <= 1'b1;
            end
          end
          ST_ISSUE: begin
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (w_release) begin
              r_pend <= w_pendCleared;
              if (done_i) begin
                r_acc <= r_acc | r_grant;
              end
              if (w_pendCleared == '0) begin
                r_state     <= ST_DONE;
                r_grant     <= '0;
                r_cycleDone <= 1'b1;
              end else begin
                r_state <= ST_ISSUE;
                r_grant <= w_pendLowest;
                r_start <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            r_served <= r_acc;
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign grant_o      = r_grant;
  assign start_o      = r_start;
  assign busy_o       = r_busy;
  assign zero_o       = r_zero;
  assign cycle_done_o = r_cycleDone;
  assign served_o     = r_served;

endmodule
